handshake_const_arbiter: RTL and testbench

Round-robin arbiter that shares one constant-token source among `NUM_REQ` control-token requesters in the elastic dataflow fabric. Each accepted control token produces one output token carrying `CONST_VALUE` and the index of the requester it served. A single registered output slot breaks the combinational valid/ready path toward the consumer while sustaining one token per cycle.

---
 rtl/handshake_const_arbiter_if.sv | 24 ++
 rtl/handshake_const_arbiter.sv | 113 +++++++++++
 tb/tb_handshake_const_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_const_arbiter_if.sv
// Requester control handshake plus the registered output token slot of handshake_const_arbiter.
// The arbiter side uses the slave modport; the requesters/consumer side uses master.
interface handshake_const_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]    ctrl_valid;
    logic [NUM_REQ-1:0]    ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic [ID_WIDTH-1:0]   outs_id;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ctrl_valid, outs_ready,
        input  ctrl_ready, outs, outs_id, outs_valid
    );

    modport slave (
        input  ctrl_valid, outs_ready,
        output ctrl_ready, outs, outs_id, outs_valid
    );
endinterface

// File: rtl/handshake_const_arbiter.sv
// Round-robin arbiter sharing one constant-token source among NUM_REQ requesters, one registered output slot.
// Build option: define HANDSHAKE_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no round-robin pointer).

// Per-requester slice: qualifies the request against the scan base and decodes its ready bit.
module handshake_const_arbiter_lane #(
    parameter int LANE     = 0,
    parameter int ID_WIDTH = 2
) (
    input  logic                i_valid,
    input  logic [ID_WIDTH-1:0] i_base,
    input  logic [ID_WIDTH-1:0] i_grant,
    input  logic                i_accept,
    output logic                o_hi_req,
    output logic                o_ready
);
    assign o_hi_req = i_valid && (LANE >= int'(i_base));
    assign o_ready  = i_accept && (i_grant == ID_WIDTH'(LANE));
endmodule

module handshake_const_arbiter #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REQ     = 4,
    parameter int          ID_WIDTH    = 2,
    parameter logic [31:0] CONST_VALUE = 32'h0000_0011
) (
    input logic                      clk,
    input logic                      rst,
    handshake_const_arbiter_if.slave bus
);
    localparam logic [0:0]            S_EMPTY = 1'b0;
    localparam logic [0:0]            S_FULL  = 1'b1;
    localparam logic [DATA_WIDTH-1:0] C_VAL   = DATA_WIDTH'(CONST_VALUE);

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_outs;
    logic [ID_WIDTH-1:0]   r_outs_id;

    logic                  w_slot_free;
    logic                  w_any;
    logic                  w_accept;
    logic [ID_WIDTH-1:0]   w_base;
    logic [NUM_REQ-1:0]    w_hi_req;
    logic [ID_WIDTH-1:0]   w_hi_grant;
    logic [ID_WIDTH-1:0]   w_lo_grant;
    logic [ID_WIDTH-1:0]   w_grant;

`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [ID_WIDTH-1:0] r_last;

    // Scan starts one past the last served requester, wrapping at NUM_REQ.
    assign w_base = (int'(r_last) == NUM_REQ - 1) ? '0 : r_last + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= ID_WIDTH'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`endif

    // Gated by reset so no requester sees ready while the block is held in reset.
    assign w_slot_free = rst && ((r_state == S_EMPTY) || bus.outs_ready);
    assign w_any       = |bus.ctrl_valid;
    assign w_accept    = w_any && w_slot_free;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        handshake_const_arbiter_lane #(
            .LANE     (gi),
            .ID_WIDTH (ID_WIDTH)
        ) u_lane (
            .i_valid  (bus.ctrl_valid[gi]),
            .i_base   (w_base),
            .i_grant  (w_grant),
            .i_accept (w_accept),
            .o_hi_req (w_hi_req[gi]),
            .o_ready  (bus.ctrl_ready[gi])
        );
    end

    // Lowest requester at/after the base wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        w_hi_grant = '0;
        w_lo_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_hi_req[i])       w_hi_grant = ID_WIDTH'(i);
            if (bus.ctrl_valid[i]) w_lo_grant = ID_WIDTH'(i);
        end
    end

    assign w_grant = (|w_hi_req) ? w_hi_grant : w_lo_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_EMPTY;
            r_outs    <= '0;
            r_outs_id <= '0;
        end else if (w_accept) begin
            r_state   <= S_FULL;
            r_outs    <= C_VAL;
            r_outs_id <= w_grant;
        end else if (bus.outs_ready) begin
            // Payload is left in place when the slot drains; only the valid drops.
            r_state   <= S_EMPTY;
        end
    end

    assign bus.outs       = r_outs;
    assign bus.outs_id    = r_outs_id;
    assign bus.outs_valid = (r_state == S_FULL);
endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Randomised self-checking bench for handshake_const_arbiter against a token-level reference model.
module tb_handshake_const_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk;
    logic rst;

    handshake_const_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IW)) bus ();

    handshake_const_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (N),
        .ID_WIDTH    (IW),
        .CONST_VALUE (32'h0000_0011)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    // Reference model: one-token slot plus the index last served.
    bit          m_full;
    int          m_id;
    logic [31:0] m_out;
    int          m_last;
    int          m_acc;

    function automatic int pick(input logic [N-1:0] v);
        int base;
`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
        base = N - 1;
`else
        base = m_last;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v, input logic ordy);
        int g;
        g = pick(v);
        if (g >= 0 && (!m_full || ordy)) return N'(1) << g;
        return '0;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 0;
        m_out  = 32'h0;
        m_last = N - 1;
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic r);
        bus.ctrl_valid = v;
        bus.outs_ready = r;
        #3;
    endtask

    task automatic tick();
        int g;
        g = pick(bus.ctrl_valid);
        if (g >= 0 && (!m_full || bus.outs_ready)) begin
            m_full = 1'b1;
            m_id   = g;
            m_out  = 32'h11;
            m_last = g;
            m_acc++;
        end else if (bus.outs_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ctrl_valid = '0;
        bus.outs_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ctrl_valid = '1;
        bus.outs_ready = 1'b1;
        #2;
        vectors++;
        if (bus.ctrl_ready !== '0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", bus.ctrl_ready);
        end
        vectors++;
        if (bus.outs_valid !== 1'b0 || bus.outs !== '0 || bus.outs_id !== '0) begin
            errors++;
            $display("FAIL reset_slot: got v=%b d=%h id=%0d expected v=0 d=0 id=0",
                     bus.outs_valid, bus.outs, bus.outs_id);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_in(4'b0001, 1'b1);
        vectors++;
        if (bus.ctrl_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b expected 0001", bus.ctrl_ready);
        end
        tick();
        set_in(4'b0000, 1'b1);
        vectors++;
        if (bus.outs_valid !== 1'b1 || bus.outs !== 32'h11 || bus.outs_id !== 2'd0) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h id=%0d expected v=1 d=11 id=0",
                     bus.outs_valid, bus.outs, bus.outs_id);
        end
        tick();
        vectors++;
        if (bus.outs_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got valid=%b expected 0", bus.outs_valid);
        end
    endtask

    task automatic test_back_to_back();
        int eg;
        int prev;
        do_reset();
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1111, 1'b1);
`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
            eg = 0;
`else
            eg = i % N;
`endif
            vectors++;
            if (bus.ctrl_ready !== (N'(1) << eg)) begin
                errors++; $display("FAIL b2b_grant[%0d]: got %b expected grant %0d", i, bus.ctrl_ready, eg);
            end
            if (i > 0) begin
                vectors++;
                if (bus.outs_valid !== 1'b1 || int'(bus.outs_id) != prev) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b id=%0d expected v=1 id=%0d",
                             i, bus.outs_valid, bus.outs_id, prev);
                end
            end
            prev = eg;
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            set_in(4'b0110, 1'b0);
            vectors++;
            if (bus.ctrl_ready !== '0 || bus.outs_valid !== 1'b1 ||
                int'(bus.outs_id) != m_id || bus.outs !== 32'h11) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d d=%h expected rdy=0000 v=1 id=%0d d=11",
                         c, bus.ctrl_ready, bus.outs_valid, bus.outs_id, bus.outs, m_id);
            end
            tick();
        end
        set_in(4'b0110, 1'b1);
        vectors++;
        if (bus.ctrl_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release: got %b expected 0010", bus.ctrl_ready);
        end
        tick();
        set_in(4'b0000, 1'b1);
        vectors++;
        if (bus.outs_valid !== 1'b1 || bus.outs_id !== 2'd1) begin
            errors++; $display("FAIL bp_refill: got v=%b id=%0d expected v=1 id=1", bus.outs_valid, bus.outs_id);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(4'b1001, 1'b1);
        vectors++;
        if (bus.ctrl_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_first: got %b expected 0001", bus.ctrl_ready);
        end
        tick();
        set_in(4'b1001, 1'b1);
        vectors++;
`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
        if (bus.ctrl_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_second: got %b expected 0001", bus.ctrl_ready);
        end
`else
        if (bus.ctrl_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_second: got %b expected 1000", bus.ctrl_ready);
        end
`endif
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(4'b0100, 1'b0);
        tick();
        set_in(4'b0000, 1'b0);
        vectors++;
        if (bus.outs_valid !== 1'b1 || bus.outs_id !== 2'd2) begin
            errors++; $display("FAIL arst_setup: got v=%b id=%0d expected v=1 id=2", bus.outs_valid, bus.outs_id);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (bus.outs_valid !== 1'b0 || bus.outs_id !== 2'd0) begin
            errors++; $display("FAIL arst_drop: got v=%b id=%0d expected v=0 id=0", bus.outs_valid, bus.outs_id);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_in(4'b1111, 1'b1);
        vectors++;
        if (bus.ctrl_ready !== 4'b0001) begin
            errors++; $display("FAIL arst_first_grant: got %b expected 0001", bus.ctrl_ready);
        end
        tick();
    endtask

    task automatic test_stress();
        logic [N-1:0] v, prev_v, prev_rdy, er;
        logic         r;
        int dut_in, dut_out, max_wait, g;
        int wait_cnt[N];
        do_reset();
        m_acc = 0; dut_in = 0; dut_out = 0; max_wait = 0;
        prev_v = '0; prev_rdy = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                v[i] = (prev_v[i] && !prev_rdy[i]) ? 1'b1 : ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            set_in(v, r);
            er = exp_ready(v, r);
            vectors++;
            if (bus.ctrl_ready !== er) begin
                errors++; $display("FAIL stress_ready[%0d]: got %b expected %b", c, bus.ctrl_ready, er);
            end
            vectors++;
            if (bus.outs_valid !== m_full || (m_full && (int'(bus.outs_id) != m_id || bus.outs !== m_out))) begin
                errors++;
                $display("FAIL stress_slot[%0d]: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h",
                         c, bus.outs_valid, bus.outs_id, bus.outs, m_full, m_id, m_out);
            end
            if (|(bus.ctrl_ready & bus.ctrl_valid)) dut_in++;
            if (bus.outs_valid && bus.outs_ready) dut_out++;
            if (er != '0) begin
                g = pick(v);
                for (int i = 0; i < N; i++) begin
                    if (i == g) wait_cnt[i] = 0;
                    else if (v[i]) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
            end
            prev_v = v;
            prev_rdy = er;
            tick();
        end
        vectors++;
        if (dut_in != m_acc) begin
            errors++; $display("FAIL stress_accepts: got %0d expected %0d", dut_in, m_acc);
        end
        vectors++;
        if (dut_out + int'(bus.outs_valid) != dut_in) begin
            errors++; $display("FAIL stress_tokens: got %0d out+held expected %0d", dut_out + int'(bus.outs_valid), dut_in);
        end
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
        vectors++;
        if (max_wait > N - 1) begin
            errors++; $display("FAIL stress_starvation: got wait %0d expected at most %0d", max_wait, N - 1);
        end
`endif
    endtask

    initial begin
        m_acc = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
